// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the serial framing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package piso_tx_pkg;

  // Frame sequencing states; PAR is only visited when parity is enabled.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Parity modes selected by the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Turns the XOR-reduction of a word into the transmitted parity bit.
  function automatic logic apply_parity(input int mode, input logic xor_red);
    if (mode == PAR_ODD) begin
      return ~xor_red;
    end
    if (mode == PAR_EVEN) begin
      return xor_red;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// WIDTH-bit parallel-in/serial-out shift register, MSB presented on dout.
// Latency: load/shift take effect on the next rising edge of Clk.
// Backpressure: none; load wins over shift when both are asserted.
module piso_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] r_q;

  // Parallel load or shift toward the MSB, filling with zero.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= din;
    end else if (shift) begin
      r_q <= r_q << 1;
    end
  end

  assign dout = r_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Serial transmitter framing: start bit, WIDTH data bits MSB first, optional parity, stop bit.
// Latency: start bit on Dout the cycle after accept; done on the last cycle of the stop bit.
// Backpressure: in_ready is high only in IDLE and on the final stop cycle (back-to-back accept).
module piso_tx_ctrl
  import piso_tx_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIV    = 1,
  parameter int PARITY = 0
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             Dout,
  output logic             busy,
  output logic             done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_t          r_state;
  logic [DW-1:0]   r_div_cnt;
  logic [BW-1:0]   r_bit_cnt;
  logic            r_par;
  logic            r_dout;
  logic            r_busy;
  logic            r_done;
  logic            r_in_ready;

  logic            w_accept;
  logic            w_bit_end;
  logic            w_last_bit;
  logic            w_shift;
  logic            w_sh_msb;
  logic            w_par_calc;
  logic [DW-1:0]   w_div_nxt;
  logic            w_stop_last_nxt;

  assign w_accept   = in_valid & r_in_ready;
  assign w_bit_end  = (r_div_cnt == DIV_LAST);
  assign w_last_bit = (r_bit_cnt == BIT_LAST);
  // The shift register runs one bit ahead of Dout: its MSB is copied into
  // r_dout on the same edge that shifts the next bit up behind it.
  assign w_shift    = w_bit_end & ((r_state == START) | ((r_state == DATA) & ~w_last_bit));
  assign w_div_nxt  = ((r_state == IDLE) || w_bit_end) ? '0 : r_div_cnt + DW'(1);
  // Tells whether the cycle after this edge is the final cycle of a bit.
  assign w_stop_last_nxt = (w_div_nxt == DIV_LAST);
  assign w_par_calc = apply_parity(PARITY, ^in_data);

  piso_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .Clk    (Clk),
    .reset_n(reset_n),
    .load   (w_accept),
    .shift  (w_shift),
    .din    (in_data),
    .dout   (w_sh_msb)
  );

  // Bit-period divider: free-runs 0..DIV-1 while a frame is active, held at 0 in IDLE.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= w_div_nxt;
    end
  end

  // Frame sequencer with registered line/handshake outputs.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_par      <= 1'b0;
      r_dout     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= START;
            r_par      <= w_par_calc;
            r_dout     <= 1'b0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state   <= DATA;
            r_bit_cnt <= '0;
            r_dout    <= w_sh_msb;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (w_last_bit) begin
              if (PARITY != PAR_NONE) begin
                r_state <= PAR;
                r_dout  <= r_par;
              end else begin
                r_state    <= STOP;
                r_dout     <= 1'b1;
                r_done     <= w_stop_last_nxt;
                r_in_ready <= w_stop_last_nxt;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
              r_dout    <= w_sh_msb;
            end
          end
        end
        PAR: begin
          if (w_bit_end) begin
            r_state    <= STOP;
            r_dout     <= 1'b1;
            r_done     <= w_stop_last_nxt;
            r_in_ready <= w_stop_last_nxt;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (w_accept) begin
              r_state    <= START;
              r_par      <= w_par_calc;
              r_dout     <= 1'b0;
              r_in_ready <= 1'b0;
            end else begin
              r_state    <= IDLE;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b1;
            end
          end else begin
            r_done     <= w_stop_last_nxt;
            r_in_ready <= w_stop_last_nxt;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign Dout     = r_dout;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: four configurations share one stimulus stream.
// Each is compared every cycle against a frame-position model, plus literal frame checks.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_piso_tx_ctrl;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic [3:0] w_rdy, w_dout, w_busy, w_done;

  always #5 Clk = ~Clk;

  piso_tx_ctrl #(.WIDTH(4), .DIV(1), .PARITY(0)) u0 (
    .Clk(Clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(w_rdy[0]), .Dout(w_dout[0]), .busy(w_busy[0]), .done(w_done[0]));
  piso_tx_ctrl #(.WIDTH(4), .DIV(1), .PARITY(1)) u1 (
    .Clk(Clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(w_rdy[1]), .Dout(w_dout[1]), .busy(w_busy[1]), .done(w_done[1]));
  piso_tx_ctrl #(.WIDTH(4), .DIV(1), .PARITY(2)) u2 (
    .Clk(Clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(w_rdy[2]), .Dout(w_dout[2]), .busy(w_busy[2]), .done(w_done[2]));
  piso_tx_ctrl #(.WIDTH(4), .DIV(3), .PARITY(0)) u3 (
    .Clk(Clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(w_rdy[3]), .Dout(w_dout[3]), .busy(w_busy[3]), .done(w_done[3]));

  int n_total = 0;
  int n_bad   = 0;
  bit en_cmp  = 1'b0;

  int div_a[4] = '{1, 1, 1, 3};
  int par_a[4] = '{0, 1, 2, 0};

  // Model state: position inside the current frame (0 = idle, 1..F = cycle of frame).
  int         m_pos[4] = '{0, 0, 0, 0};
  logic [3:0] m_dat[4];

  logic rec_d[4][32];
  logic rec_done[4][32];
  logic rec_rdy[4][32];
  logic rec_busy[4][32];

  function automatic int flen(int i);
    return (4 + 2 + ((par_a[i] != 0) ? 1 : 0)) * div_a[i];
  endfunction

  // Line level at frame cycle pos: bit index is (pos-1)/DIV within start,d3..d0,[par],stop.
  function automatic logic exp_bit(int i, int pos, logic [3:0] d);
    int b;
    b = (pos - 1) / div_a[i];
    if (b == 0) return 1'b0;
    if (b <= 4) return d[4 - b];
    if (par_a[i] != 0 && b == 5) return (par_a[i] == 1) ? ^d : ~(^d);
    return 1'b1;
  endfunction

  function automatic logic exp_dout(int i);
    return (m_pos[i] == 0) ? 1'b1 : exp_bit(i, m_pos[i], m_dat[i]);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advance frame position, start a new frame whenever a word is accepted.
  always @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) m_pos[i] <= 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (in_valid && (m_pos[i] == 0 || m_pos[i] == flen(i))) begin
          m_pos[i] <= 1;
          m_dat[i] <= in_data;
        end else if (m_pos[i] != 0) begin
          m_pos[i] <= (m_pos[i] == flen(i)) ? 0 : m_pos[i] + 1;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge Clk) begin
    if (en_cmp) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("dout[%0d]", i), w_dout[i], exp_dout(i));
        chk($sformatf("busy[%0d]", i), w_busy[i], (m_pos[i] != 0) ? 1 : 0);
        chk($sformatf("done[%0d]", i), w_done[i], (m_pos[i] == flen(i)) ? 1 : 0);
        chk($sformatf("ready[%0d]", i), w_rdy[i],
            (m_pos[i] == 0 || m_pos[i] == flen(i)) ? 1 : 0);
      end
    end
  end

  task automatic rec(int c);
    for (int i = 0; i < 4; i++) begin
      rec_d[i][c]    = w_dout[i];
      rec_done[i][c] = w_done[i];
      rec_rdy[i][c]  = w_rdy[i];
      rec_busy[i][c] = w_busy[i];
    end
  endtask

  task automatic check_seq(string nm, int i, logic [31:0] seq, int n, int d1, int d2);
    for (int c = 1; c <= n; c++) begin
      chk($sformatf("%s_dout_c%0d", nm, c), rec_d[i][c], seq[n - c]);
      chk($sformatf("%s_done_c%0d", nm, c), rec_done[i][c], (c == d1 || c == d2) ? 1 : 0);
    end
  endtask

  task automatic check_reset_vals(string nm);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_dout[%0d]", nm, i), w_dout[i], 1);
      chk($sformatf("%s_busy[%0d]", nm, i), w_busy[i], 0);
      chk($sformatf("%s_ready[%0d]", nm, i), w_rdy[i], 1);
      chk($sformatf("%s_done[%0d]", nm, i), w_done[i], 0);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    repeat (3) @(negedge Clk);
    check_reset_vals("reset");
    #1 reset_n = 1'b1;
    en_cmp = 1'b1;
    repeat (2) @(negedge Clk);

    // Single word 1011 into every configuration.
    #1 in_valid = 1'b1; in_data = 4'b1011;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      rec(c);
      if (c == 6) chk("model_odd_parity_bit", exp_dout(2), 0);
      #1 in_valid = 1'b0;
    end
    check_seq("basic",  0, 32'b0101111, 7, 6, -1);
    chk("basic_busy_c6", rec_busy[0][6], 1);
    chk("basic_busy_c7", rec_busy[0][7], 0);
    check_seq("even",   1, 32'b0101111, 7, 7, -1);
    check_seq("odd",    2, 32'b0101101, 7, 7, -1);

    // Divide-by-3 frame with 0110.
    #1 in_valid = 1'b1; in_data = 4'b0110;
    for (int c = 1; c <= 24; c++) begin
      @(negedge Clk);
      rec(c);
      #1 in_valid = 1'b0;
    end
    check_seq("div3", 3, 32'b0000001111110001111, 19, 18, -1);
    for (int c = 1; c <= 19; c++)
      chk($sformatf("div3_ready_c%0d", c), rec_rdy[3][c], (c >= 18) ? 1 : 0);

    // Back-to-back: valid held through the first frame's done cycle.
    #1 in_valid = 1'b1; in_data = 4'hA;
    for (int c = 1; c <= 24; c++) begin
      @(negedge Clk);
      rec(c);
      #1;
      if (c == 1) in_data = 4'h5;
      if (c == 7) in_valid = 1'b0;
    end
    check_seq("b2b", 0, 32'b0101010010111, 13, 6, 12);
    for (int c = 1; c <= 13; c++)
      chk($sformatf("b2b_busy_c%0d", c), rec_busy[0][c], (c <= 12) ? 1 : 0);

    // Reset asserted during data bit 2 of a frame.
    #1 in_valid = 1'b1; in_data = 4'b1011;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      rec(c);
      #1 in_valid = 1'b0;
    end
    chk("pre_reset_busy", rec_busy[0][4], 1);
    reset_n = 1'b0;
    #1 check_reset_vals("midreset");
    repeat (2) @(negedge Clk);
    #1 reset_n = 1'b1;
    in_valid = 1'b1; in_data = 4'h3;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      rec(c);
      #1 in_valid = 1'b0;
    end
    check_seq("after_reset", 0, 32'b00011111, 8, 6, -1);
    repeat (20) @(negedge Clk);

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int k = 0; k < 3000; k++) begin
      @(negedge Clk);
      #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 4'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end
    @(negedge Clk);
    en_cmp = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_tx_ctrl.md
# piso_tx_ctrl

Framing controller that drives the team's 4-bit parallel-in/serial-out shift register as a serial transmitter. It accepts parallel words over a valid/ready handshake and loads the word into the shift register. It then sequences the shifts at a programmable bit rate, wrapping each word in a start bit, optional parity and a stop bit. It sits between a word producer (register file or FIFO) and a single serial output line.

## Interface
Parameters:
- WIDTH, 4, data bits per frame (≥1).
- DIV, 1, clock cycles per serial bit (≥1).
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset; deassertion assumed synchronous to Clk upstream.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WIDTH  parallel word, sampled only on accept.
- in_ready  output  1  controller can accept a word this cycle.
- Dout  output  1  serial line; idle level 1.
- busy  output  1  frame in progress (any state but IDLE).
- done  output  1  one-cycle pulse on the last cycle of each stop bit.

## Operation
- States: IDLE, START, DATA, PAR, STOP. PAR is skipped when PARITY=0.
- Accept = in_valid & in_ready at a rising edge. On accept:
  - in_data is loaded into the shift register.
  - Parity of in_data is computed and held: even → XOR of bits; odd → inverted XOR.
  - The state moves to START.
- START: Dout=0 for DIV cycles.
- DATA: WIDTH bits, MSB (in_data[WIDTH-1]) first, DIV cycles each.
  - The shift register shifts once per bit boundary.
  - The bit counter counts 0..WIDTH-1.
- PAR: Dout=held parity bit for DIV cycles.
- STOP: Dout=1 for DIV cycles.
  - done=1 and in_ready=1 on its final cycle.
  - If accepted then, go to START (back-to-back, no idle gap); otherwise go to IDLE.
- IDLE: Dout=1, in_ready=1, busy=0.
- While busy (except the final STOP cycle):
  - in_ready=0.
  - in_valid and in_data are ignored.
  - A producer holding in_valid keeps it until accepted.
- Divider counter counts 0..DIV-1 and wraps. With DIV=1 it is constant 0 and every cycle is a bit boundary.
- Counter widths: divider $clog2(DIV) (minimum 1), bit counter $clog2(WIDTH) (minimum 1). No counter may overflow for any legal parameter.

## Timing
- Reset values:
  - State IDLE, Dout=1, in_ready=1, busy=0, done=0.
  - Shift register, parity register and counters all 0.
- Reset is asynchronous. Assertion mid-frame immediately forces all reset values: the frame is discarded, no done pulse.
- Frame length F = (WIDTH + 2 + (PARITY≠0)) × DIV cycles.
  - Start bit appears on Dout the cycle after accept.
  - done is asserted in cycle F after accept (accept edge = cycle 0).
- Back-to-back throughput: one frame per F cycles exactly.
- Outputs are registered: Dout, busy, done and in_ready change only on Clk edges or on reset.

## Structure
- Package piso_tx_pkg holds:
  - the state enum (IDLE, START, DATA, PAR, STOP);
  - the parity mode constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2).
- Sub-module piso_shreg: WIDTH-parameterized shift register.
  - Ports: Clk, reset_n, load, shift, din[WIDTH-1:0], dout (MSB).
  - load has priority over shift.
- piso_tx_ctrl holds the FSM, divider, bit counter and parity logic, and instantiates one piso_shreg.

## Test plan
- Basic frame (WIDTH=4, DIV=1, PARITY=0): accept 4'b1011.
  - Dout = 0,1,0,1,1,1 over cycles 1–6.
  - done high in cycle 6 only; busy low from cycle 7.
- Even parity (PARITY=1): accept 4'b1011.
  - Dout = 0,1,0,1,1,1(parity),1(stop); done in cycle 7.
- Odd parity (PARITY=2): accept 4'b1011.
  - Parity bit = 0; frame is 0,1,0,1,1,0,1.
- Divider (DIV=3): accept 4'b0110.
  - Each bit is held exactly 3 cycles.
  - done in cycle 18; in_ready low during cycles 1–17.
- Back-to-back: in_valid held high with 4'hA then 4'h5.
  - Second accept occurs on the first word's done cycle.
  - Start bit of word 2 immediately follows the stop bit of word 1; no idle cycle.
- Reset mid-frame: assert reset_n=0 during DATA bit 2.
  - Dout=1, busy=0, in_ready=1 immediately; no done pulse.
  - After release, a new accept of 4'h3 produces a correct full frame.
